// File: rtl/base_lane_pack_pkg.sv
// Shared types and helpers for the lane packer.
package base_lane_pack_pkg;

    localparam int MAX_WAYS = 32;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Lanes 0..cnt-1 enabled; callers truncate to their own lane count.
    function automatic logic [MAX_WAYS-1:0] lane_mask(input int cnt);
        logic [MAX_WAYS-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_WAYS; i++) begin
            m[i] = (i < cnt);
        end
        return m;
    endfunction

endpackage

// File: rtl/base_rotl_enc.sv
// Lane rotator: output lane j takes input lane (j+sel) mod oways.
module base_rotl_enc #(
    parameter int oways     = 4,
    parameter int width     = 8,
    parameter int sel_width = $clog2(oways)
) (
    input  logic [oways*width-1:0] in_d,
    input  logic [sel_width-1:0]   sel,
    output logic [oways*width-1:0] out_d
);

    always_comb begin
        out_d = '0;
        for (int j = 0; j < oways; j++) begin
            out_d[j*width +: width] = in_d[((j + int'(sel)) % oways)*width +: width];
        end
    end

endmodule

// File: rtl/base_lane_pack.sv
// Streaming lane packer: repacks left-justified partial beats into dense output beats.
//   state | meaning
//   RUN   | accepting input beats, packing into hold / output slot
//   FLUSH | emitting the residual hold lanes of an end-of-packet overflow
module base_lane_pack
    import base_lane_pack_pkg::*;
#(
    parameter int width     = 8,
    parameter int ways      = 4,
    parameter int cnt_width = $clog2(ways+1),
    parameter int sel_width = $clog2(ways)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_v,
    output logic                   i_r,
    input  logic [ways*width-1:0]  i_d,
    input  logic [cnt_width-1:0]   i_cnt,
    input  logic                   i_end,
    output logic                   o_v,
    input  logic                   o_r,
    output logic [ways*width-1:0]  o_d,
    output logic [cnt_width-1:0]   o_cnt,
    output logic                   o_end
);

    state_t                 state_q, state_d;
    logic [sel_width-1:0]   f_q, f_d;
    logic [ways*width-1:0]  hold_q, hold_d;
    logic                   o_v_q, o_v_d;
    logic [ways*width-1:0]  o_d_q, o_d_d;
    logic [cnt_width-1:0]   o_cnt_q, o_cnt_d;
    logic                   o_end_q, o_end_d;

    logic [ways-1:0]        in_en;
    logic [ways*width-1:0]  in_m, rot, comb_lanes, wrap_lanes;
    logic [sel_width-1:0]   sel;
    logic                   slot_free, acc;
    int                     s_i;

    // Invalid input lanes are zeroed up front so zero-fill falls out of the steering.
    always_comb begin
        in_en = ways'(lane_mask(int'(i_cnt)));
        in_m  = '0;
        for (int k = 0; k < ways; k++) begin
            in_m[k*width +: width] = in_en[k] ? i_d[k*width +: width] : '0;
        end
        sel = (f_q == '0) ? '0 : sel_width'(ways - int'(f_q));
    end

    base_rotl_enc #(
        .oways     (ways),
        .width     (width),
        .sel_width (sel_width)
    ) u_rotl (
        .in_d  (in_m),
        .sel   (sel),
        .out_d (rot)
    );

    assign slot_free = !o_v_q || o_r;
    assign i_r       = !reset && (state_q == RUN) && slot_free;
    assign acc       = i_v && i_r;

    always_comb begin
        state_d = state_q;
        f_d     = f_q;
        hold_d  = hold_q;
        o_v_d   = o_v_q;
        o_d_d   = o_d_q;
        o_cnt_d = o_cnt_q;
        o_end_d = o_end_q;

        s_i = int'(f_q) + int'(i_cnt);
        comb_lanes = '0;
        wrap_lanes = '0;
        for (int j = 0; j < ways; j++) begin
            comb_lanes[j*width +: width] = (j < int'(f_q)) ? hold_q[j*width +: width]
                                                           : rot[j*width +: width];
            if (j < s_i - ways) begin
                wrap_lanes[j*width +: width] = rot[j*width +: width];
            end
        end

        if (slot_free) begin
            o_v_d = 1'b0;
        end

        if (state_q == FLUSH) begin
            if (slot_free) begin
                o_v_d   = 1'b1;
                o_d_d   = hold_q;
                o_cnt_d = cnt_width'(int'(f_q));
                o_end_d = 1'b1;
                hold_d  = '0;
                f_d     = '0;
                state_d = RUN;
            end
        end else if (acc) begin
            if (!i_end && s_i < ways) begin
                hold_d = comb_lanes;
                f_d    = sel_width'(s_i);
            end else if (i_end && s_i <= ways) begin
                o_v_d   = 1'b1;
                o_d_d   = comb_lanes;
                o_cnt_d = cnt_width'(s_i);
                o_end_d = 1'b1;
                hold_d  = '0;
                f_d     = '0;
            end else begin
                o_v_d   = 1'b1;
                o_d_d   = comb_lanes;
                o_cnt_d = cnt_width'(ways);
                o_end_d = 1'b0;
                hold_d  = wrap_lanes;
                f_d     = sel_width'(s_i - ways);
                if (i_end) begin
                    state_d = FLUSH;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            f_q     <= '0;
            hold_q  <= '0;
            o_v_q   <= 1'b0;
            o_d_q   <= '0;
            o_cnt_q <= '0;
            o_end_q <= 1'b0;
        end else begin
            state_q <= state_d;
            f_q     <= f_d;
            hold_q  <= hold_d;
            o_v_q   <= o_v_d;
            o_d_q   <= o_d_d;
            o_cnt_q <= o_cnt_d;
            o_end_q <= o_end_d;
        end
    end

    assign o_v   = o_v_q;
    assign o_d   = o_d_q;
    assign o_cnt = o_cnt_q;
    assign o_end = o_end_q;

    a_cnt_legal: assert property (@(posedge clk) disable iff (reset)
        (i_v && i_r) |-> (int'(i_cnt) <= ways));

endmodule

// File: tb/tb_base_lane_pack.sv
// Directed bench for base_lane_pack with a lane-level scoreboard of expected beats.
module tb_base_lane_pack;

    typedef struct packed {
        logic [31:0] d;
        logic [2:0]  cnt;
        logic        e;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_v, i_r, i_end;
    logic [31:0] i_d;
    logic [2:0]  i_cnt;
    logic        o_v, o_r, o_end;
    logic [31:0] o_d;
    logic [2:0]  o_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    beat_t      exp_q[$];
    logic [7:0] pend[$];

    base_lane_pack #(.width(8), .ways(4)) dut (
        .clk   (clk),
        .reset (reset),
        .i_v   (i_v),
        .i_r   (i_r),
        .i_d   (i_d),
        .i_cnt (i_cnt),
        .i_end (i_end),
        .o_v   (o_v),
        .o_r   (o_r),
        .o_d   (o_d),
        .o_cnt (o_cnt),
        .o_end (o_end)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [7:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic emit(input int n, input logic e);
        beat_t b;
        b.d = '0;
        for (int k = 0; k < n; k++) b.d[k*8 +: 8] = pend.pop_front();
        b.cnt = 3'(n);
        b.e   = e;
        exp_q.push_back(b);
    endtask

    // Reference packing model: a flat lane queue cut into beats.
    task automatic model_push(input logic [31:0] d, input int cnt, input logic e);
        for (int k = 0; k < cnt; k++) pend.push_back(d[k*8 +: 8]);
        if (!e) begin
            if (pend.size() >= 4) emit(4, 1'b0);
        end else if (pend.size() <= 4) begin
            emit(pend.size(), 1'b1);
        end else begin
            emit(4, 1'b0);
            emit(pend.size(), 1'b1);
        end
    endtask

    task automatic send(input logic [31:0] d, input int cnt, input logic e);
        bit ok;
        ok    = 0;
        i_d   = d;
        i_cnt = 3'(cnt);
        i_end = e;
        i_v   = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (i_r) begin
                ok = 1;
                break;
            end
        end
        check("accept_timeout", 32'(ok), 32'd1);
        if (ok) begin
            model_push(d, cnt, e);
            @(posedge clk);
        end
        #1;
        i_v = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && o_v && o_r) begin
            if (exp_q.size() == 0) begin
                check("extra_beat", 32'(exp_q.size()), 32'd1);
            end else begin
                beat_t b;
                b = exp_q.pop_front();
                check("o_d", o_d, b.d);
                check("o_cnt", 32'(o_cnt), 32'(b.cnt));
                check("o_end", 32'(o_end), 32'(b.e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        i_v   = 1'b1;
        i_d   = 32'h12345678;
        i_cnt = 3'd3;
        i_end = 1'b0;
        o_r   = 1'b1;

        repeat (3) begin
            @(negedge clk);
            check("rst_i_r", 32'(i_r), 32'd0);
            check("rst_o_v", 32'(o_v), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        i_v   = 1'b0;
        @(negedge clk);
        check("rel_i_r", 32'(i_r), 32'd1);
        check("rel_o_v", 32'(o_v), 32'd0);
        @(posedge clk); #1;

        // pack across beats, garbage in lanes past the count
        send(lanes(8'hA0, 8'hA1, 8'hA2, 8'hEE), 3, 1'b0);
        send(lanes(8'hB0, 8'hB1, 8'hB2, 8'hEE), 3, 1'b0);
        send(lanes(8'hC0, 8'hC1, 8'hEE, 8'hEE), 2, 1'b0);
        repeat (3) @(posedge clk); #1;
        check("pack_f", 32'(dut.f_q), 32'd0);
        check("pack_drain", 32'(exp_q.size()), 32'd0);

        // overflow at end of packet forces FLUSH
        send(lanes(8'h10, 8'h11, 8'h12, 8'hEE), 3, 1'b0);
        check("ovf_f3", 32'(dut.f_q), 32'd3);
        send(lanes(8'h20, 8'h21, 8'h22, 8'hEE), 3, 1'b1);
        @(negedge clk);
        check("flush_bubble", 32'(i_r), 32'd0);
        @(negedge clk);
        check("flush_done", 32'(i_r), 32'd1);
        @(posedge clk); #1;
        repeat (2) @(posedge clk); #1;
        check("ovf_drain", 32'(exp_q.size()), 32'd0);

        // exact fill with end, then zero-length end marker
        send(lanes(8'h30, 8'h31, 8'hEE, 8'hEE), 2, 1'b0);
        send(lanes(8'h32, 8'h33, 8'hEE, 8'hEE), 2, 1'b1);
        send(32'hDEADBEEF, 0, 1'b1);
        repeat (3) @(posedge clk); #1;
        check("exact_drain", 32'(exp_q.size()), 32'd0);

        // backpressure on a pending full beat
        o_r = 1'b0;
        send(lanes(8'h40, 8'h41, 8'h42, 8'h43), 4, 1'b0);
        fork
            send(lanes(8'h50, 8'h51, 8'h52, 8'hEE), 3, 1'b0);
            begin
                beat_t b;
                b = exp_q[0];
                repeat (5) begin
                    @(negedge clk);
                    check("bp_o_d", o_d, b.d);
                    check("bp_o_v", 32'(o_v), 32'd1);
                    check("bp_i_r", 32'(i_r), 32'd0);
                end
                @(posedge clk); #1;
                o_r = 1'b1;
            end
        join
        send(lanes(8'h53, 8'hEE, 8'hEE, 8'hEE), 1, 1'b1);
        repeat (3) @(posedge clk); #1;
        check("bp_drain", 32'(exp_q.size()), 32'd0);

        // reset while in FLUSH discards everything pending
        send(lanes(8'h60, 8'h61, 8'h62, 8'hEE), 3, 1'b0);
        send(lanes(8'h70, 8'h71, 8'h72, 8'hEE), 3, 1'b1);
        reset = 1'b1;
        pend.delete();
        exp_q.delete();
        @(negedge clk);
        check("rstf_i_r", 32'(i_r), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rstf_o_v", 32'(o_v), 32'd0);
        check("rstf_f", 32'(dut.f_q), 32'd0);
        @(posedge clk); #1;
        send(lanes(8'h80, 8'h81, 8'hEE, 8'hEE), 2, 1'b1);
        repeat (3) @(posedge clk); #1;
        check("rstf_drain", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
